// File: rtl/note_game_pkg.sv
// Shared definitions for the note lane engine: play states, colours and
// the lane geometry helper used by both the pixel mux and its span limits.
package note_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } play_state_t;

  localparam logic [23:0] BLOCK_COLOR = 24'h000000;
  localparam logic [23:0] HIT_COLOR   = 24'hFFF200;
  localparam logic [23:0] LINE_COLOR  = 24'h808080;
  localparam logic [23:0] BG_WHITE    = 24'hFFFFFF;

  // Left edge x of lane i for a given origin and pitch.
  function automatic logic [10:0] lane_x(input int i, input int x0, input int pitch);
    return 11'(x0 + i * pitch);
  endfunction

endpackage

// File: rtl/note_lane.sv
// One scrolling note lane: DEPTH one-bit rows, row 0 at the top, the judge
// row at DEPTH-1. Handles inject on tick, hit-window search and clear, and
// produces single-cycle hit/miss pulses for the shared counters.
module note_lane #(
  parameter int DEPTH      = 400,
  parameter int HIT_WINDOW = 8
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic             inject,
  input  logic             press,
  output logic [DEPTH-1:0] bits,
  output logic             hit,
  output logic             miss
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] bits_reg;
  logic [DEPTH-1:0] bits_next;
  logic [DEPTH-1:0] cleared;
  logic             found;
  logic [IDX_W-1:0] hit_idx;

  // Find the set bit in the window nearest the judge row (later index wins).
  always_comb begin
    found   = 1'b0;
    hit_idx = '0;
    for (int r = DEPTH - HIT_WINDOW; r < DEPTH; r++) begin
      if (bits_reg[r]) begin
        found   = 1'b1;
        hit_idx = IDX_W'(r);
      end
    end
  end

  // Clear the hit on the pre-shift contents, then shift; a bit hit at the
  // judge row on a tick therefore never reaches the miss test.
  always_comb begin
    hit     = press & found;
    cleared = bits_reg;
    if (hit) begin
      cleared[hit_idx] = 1'b0;
    end
    miss      = tick & cleared[DEPTH-1];
    bits_next = cleared;
    if (clr) begin
      bits_next = '0;
    end else if (tick) begin
      bits_next = {cleared[DEPTH-2:0], inject};
    end
  end

  // Lane storage.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_reg <= '0;
    end else begin
      bits_reg <= bits_next;
    end
  end

  assign bits = bits_reg;

endmodule

// File: rtl/note_lane_judge.sv
// Rhythm-game lane engine: play-control FSM, scroll tick, NUM_LANES judged
// note lanes, score/combo/miss counters and the registered pixel colour mux.
module note_lane_judge
  import note_game_pkg::*;
#(
  parameter int NUM_LANES   = 7,
  parameter int DEPTH       = 400,
  parameter int TICK_PERIOD = 100000,
  parameter int HIT_WINDOW  = 8,
  parameter int LANE_X0     = 112,
  parameter int LANE_PITCH  = 64,
  parameter int LANE_W      = 32,
  parameter int SCORE_W     = 16
) (
  input  logic                 vga_clk,
  input  logic                 rst_n,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  input  logic [1:0]           shift,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 song_end,
  input  logic [NUM_LANES-1:0] note,
  input  logic                 note_valid,
  input  logic [NUM_LANES-1:0] key,
  output logic [23:0]          pos_data,
  output logic [NUM_LANES-1:0] lane_bottom,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   miss_cnt,
  output logic [7:0]           combo,
  output logic [1:0]           state,
  output logic                 done
);

  localparam int CNT_W = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [10:0] DEPTH_Y = 11'(DEPTH);
  localparam logic [10:0] WIN_Y   = 11'(DEPTH - HIT_WINDOW);
  localparam logic [10:0] SPAN_L  = 11'(LANE_X0);
  localparam logic [10:0] SPAN_R  = lane_x(NUM_LANES - 1, LANE_X0, LANE_PITCH) + 11'(LANE_W);

  // Lane regions must not overlap, otherwise the pixel mux priority is ambiguous.
  if (LANE_W > LANE_PITCH) begin : g_geom_check
    $error("note_lane_judge: LANE_W must not exceed LANE_PITCH");
  end

  play_state_t state_reg, state_next;
  logic clr_all;
  logic active;
  logic tick;
  logic [CNT_W-1:0] tick_cnt_reg;
  logic [NUM_LANES-1:0] key_prev_reg;
  logic [NUM_LANES-1:0] press_vec, hit_vec, miss_vec, lane_busy;
  logic [DEPTH-1:0] lane_bits [NUM_LANES];
  logic [SCORE_W-1:0] score_reg, score_next, miss_reg, miss_next;
  logic [7:0] combo_reg, combo_next;
  logic [23:0] pos_data_reg, pix_next;

  assign active    = ((state_reg == ST_RUN) || (state_reg == ST_FLUSH)) && !pause;
  assign tick      = active && (tick_cnt_reg == CNT_W'(TICK_PERIOD - 1));
  assign press_vec = key & ~key_prev_reg & {NUM_LANES{active}};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    note_lane #(
      .DEPTH     (DEPTH),
      .HIT_WINDOW(HIT_WINDOW)
    ) u_lane (
      .vga_clk(vga_clk),
      .rst_n  (rst_n),
      .clr    (clr_all),
      .tick   (tick),
      .inject (note[gi] & note_valid & (state_reg == ST_RUN)),
      .press  (press_vec[gi]),
      .bits   (lane_bits[gi]),
      .hit    (hit_vec[gi]),
      .miss   (miss_vec[gi])
    );
    assign lane_bottom[gi] = lane_bits[gi][DEPTH-1];
    assign lane_busy[gi]   = |lane_bits[gi];
  end

  // Play-control state register.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state; a (re)start from IDLE or DONE clears lanes, counters and tick phase.
  always_comb begin
    state_next = state_reg;
    clr_all    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          clr_all    = 1'b1;
        end
      end
      ST_RUN:   if (song_end) state_next = ST_FLUSH;
      ST_FLUSH: if (lane_busy == '0) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Scroll tick counter; frozen by pause and outside RUN/FLUSH.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (clr_all) begin
      tick_cnt_reg <= '0;
    end else if (active) begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
    end
  end

  // Previous key levels for rising-edge detection.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev_reg <= '0;
    end else begin
      key_prev_reg <= key;
    end
  end

  // Scoring: bonus uses the pre-update combo; any miss this cycle zeroes the combo.
  always_comb begin
    logic [7:0]         n_hits;
    logic [7:0]         n_miss;
    logic [8:0]         add_pts;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W:0]   miss_sum;
    logic [8:0]         combo_sum;
    n_hits = '0;
    n_miss = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_hits = n_hits + 8'(hit_vec[i]);
      n_miss = n_miss + 8'(miss_vec[i]);
    end
    add_pts    = (combo_reg >= 8'd10) ? {n_hits, 1'b0} : {1'b0, n_hits};
    score_sum  = {1'b0, score_reg} + (SCORE_W + 1)'(add_pts);
    miss_sum   = {1'b0, miss_reg} + (SCORE_W + 1)'(n_miss);
    combo_sum  = {1'b0, combo_reg} + {1'b0, n_hits};
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    miss_next  = miss_sum[SCORE_W] ? '1 : miss_sum[SCORE_W-1:0];
    if (n_miss != 8'd0) begin
      combo_next = 8'd0;
    end else begin
      combo_next = combo_sum[8] ? 8'hFF : combo_sum[7:0];
    end
  end

  // Score, miss and combo registers.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      score_reg <= '0;
      miss_reg  <= '0;
      combo_reg <= '0;
    end else if (clr_all) begin
      score_reg <= '0;
      miss_reg  <= '0;
      combo_reg <= '0;
    end else begin
      score_reg <= score_next;
      miss_reg  <= miss_next;
      combo_reg <= combo_next;
    end
  end

  // Pixel colour: notes over the judge line over the tinted background.
  always_comb begin
    logic [10:0] x11;
    logic [10:0] y11;
    logic [7:0]  t;
    x11 = {1'b0, pos_x};
    y11 = {1'b0, pos_y};
    t   = 8'({pos_y, 1'b0} / 11'd3 - 11'd1);
    case (shift)
      2'b10:   pix_next = {t, t, 8'hFF};
      2'b01:   pix_next = {8'hFF, t, t};
      default: pix_next = BG_WHITE;
    endcase
    if ((y11 >= DEPTH_Y) && (y11 <= DEPTH_Y + 11'd1) && (x11 >= SPAN_L) && (x11 < SPAN_R)) begin
      pix_next = LINE_COLOR;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((x11 >= lane_x(i, LANE_X0, LANE_PITCH)) &&
          (x11 < lane_x(i, LANE_X0, LANE_PITCH) + 11'(LANE_W)) &&
          (y11 < DEPTH_Y) && lane_bits[i][pos_y[IDX_W-1:0]]) begin
        pix_next = (key[i] && (y11 >= WIN_Y)) ? HIT_COLOR : BLOCK_COLOR;
      end
    end
  end

  // One-cycle registered pixel output.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_data_reg <= BG_WHITE;
    end else begin
      pos_data_reg <= pix_next;
    end
  end

  assign pos_data = pos_data_reg;
  assign score    = score_reg;
  assign miss_cnt = miss_reg;
  assign combo    = combo_reg;
  assign state    = state_reg;
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_note_lane_judge.sv
// Self-checking bench for note_lane_judge with a small 16-row geometry.
// Scroll ticks land on every 4th edge after the start edge, so the hand
// sequences count edges from start to place notes and presses exactly.
module tb_note_lane_judge;

  localparam int NL = 7;

  logic          vga_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    pos_x = '0;
  logic [9:0]    pos_y = '0;
  logic [1:0]    shift = '0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          song_end = 1'b0;
  logic [NL-1:0] note = '0;
  logic          note_valid = 1'b0;
  logic [NL-1:0] key = '0;
  logic [23:0]   pos_data;
  logic [NL-1:0] lane_bottom;
  logic [15:0]   score;
  logic [15:0]   miss_cnt;
  logic [7:0]    combo;
  logic [1:0]    state;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]    x;
    logic [9:0]    y;
    logic [1:0]    sh;
    logic [NL-1:0] k;
    logic [23:0]   exp;
  } pix_vec_t;

  pix_vec_t    tab_a [15];
  pix_vec_t    tab_b [5];
  logic [23:0] exp_q [$];

  note_lane_judge #(
    .NUM_LANES  (NL),
    .DEPTH      (16),
    .TICK_PERIOD(4),
    .HIT_WINDOW (3),
    .LANE_X0    (112),
    .LANE_PITCH (64),
    .LANE_W     (32),
    .SCORE_W    (16)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .shift      (shift),
    .start      (start),
    .pause      (pause),
    .song_end   (song_end),
    .note       (note),
    .note_valid (note_valid),
    .key        (key),
    .pos_data   (pos_data),
    .lane_bottom(lane_bottom),
    .score      (score),
    .miss_cnt   (miss_cnt),
    .combo      (combo),
    .state      (state),
    .done       (done)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge vga_clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pos_data", 32'(pos_data), 32'hFFFFFF);
    check("rst_counters", {score, miss_cnt} | 32'(combo), 32'd0);
    check("rst_outs", 32'({lane_bottom, done}), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  // Start edge becomes E0; returns at E0+1.
  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Holding a note for exactly one tick period injects it exactly once.
  task automatic inject(input logic [NL-1:0] n);
    note = n;
    note_valid = 1'b1;
    step(4);
    note_valid = 1'b0;
    note = '0;
  endtask

  task automatic apply_pix(input pix_vec_t v, input string tag, input int idx);
    logic [23:0] e;
    pos_x = v.x;
    pos_y = v.y;
    shift = v.sh;
    key   = v.k;
    exp_q.push_back(v.exp);
    step(1);
    if (exp_q.size() == 0) begin
      check($sformatf("%s[%0d]_queue", tag, idx), 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d] x=%0d y=%0d sh=%b", tag, idx, v.x, v.y, v.sh), 32'(pos_data), 32'(e));
    end
  endtask

  initial begin
    tab_a[0]  = '{10'd0,   10'd30, 2'b10, 7'd0,         24'h1313FF};
    tab_a[1]  = '{10'd0,   10'd30, 2'b01, 7'd0,         24'hFF1313};
    tab_a[2]  = '{10'd0,   10'd30, 2'b00, 7'd0,         24'hFFFFFF};
    tab_a[3]  = '{10'd176, 10'd5,  2'b00, 7'd0,         24'h000000};
    tab_a[4]  = '{10'd207, 10'd5,  2'b00, 7'd0,         24'h000000};
    tab_a[5]  = '{10'd208, 10'd5,  2'b00, 7'd0,         24'hFFFFFF};
    tab_a[6]  = '{10'd175, 10'd5,  2'b00, 7'd0,         24'hFFFFFF};
    tab_a[7]  = '{10'd176, 10'd6,  2'b10, 7'd0,         24'h0303FF};
    tab_a[8]  = '{10'd112, 10'd16, 2'b00, 7'd0,         24'h808080};
    tab_a[9]  = '{10'd527, 10'd17, 2'b00, 7'd0,         24'h808080};
    tab_a[10] = '{10'd528, 10'd16, 2'b00, 7'd0,         24'hFFFFFF};
    tab_a[11] = '{10'd111, 10'd16, 2'b00, 7'd0,         24'hFFFFFF};
    tab_a[12] = '{10'd112, 10'd18, 2'b01, 7'd0,         24'hFF0B0B};
    tab_a[13] = '{10'd0,   10'd0,  2'b10, 7'd0,         24'hFFFFFF};
    tab_a[14] = '{10'd176, 10'd5,  2'b00, 7'b0000010,   24'h000000};
    tab_b[0]  = '{10'd176, 10'd13, 2'b00, 7'b0000010,   24'hFFF200};
    tab_b[1]  = '{10'd207, 10'd13, 2'b00, 7'b0000010,   24'hFFF200};
    tab_b[2]  = '{10'd176, 10'd12, 2'b00, 7'b0000010,   24'hFFFFFF};
    tab_b[3]  = '{10'd176, 10'd13, 2'b00, 7'b0000000,   24'h000000};
    tab_b[4]  = '{10'd240, 10'd13, 2'b10, 7'b0000100,   24'h0707FF};

    // Unhit note reaches the judge row after 16 ticks, then misses.
    do_reset();
    do_start();
    inject(7'b0000001);          // tick at E4
    step(60);                    // E64+1: row 15
    check("t1_bottom", 32'(lane_bottom), 32'h01);
    check("t1_no_miss_yet", 32'(miss_cnt), 32'd0);
    step(4);                     // E68 tick: leaves
    check("t1_miss", 32'(miss_cnt), 32'd1);
    check("t1_combo", 32'(combo), 32'd0);
    check("t1_bottom_gone", 32'(lane_bottom), 32'h00);

    // Hit at row 14, then a second press finds nothing.
    do_reset();
    do_start();
    inject(7'b0000001);
    step(56);                    // E60+1: row 14
    key = 7'b0000001;
    step(1);
    check("t2_score", 32'(score), 32'd1);
    check("t2_combo", 32'(combo), 32'd1);
    key = '0;
    step(1);
    key = 7'b0000001;
    step(1);
    check("t2_repress_score", 32'(score), 32'd1);
    check("t2_repress_combo", 32'(combo), 32'd1);
    key = '0;
    step(1);                     // E64+1: bit would sit at row 15
    check("t2_cleared", 32'(lane_bottom), 32'h00);
    step(8);
    check("t2_no_miss", 32'(miss_cnt), 32'd0);

    // Twelve consecutive hits in lane 3, then one miss.
    do_reset();
    do_start();
    note = 7'b0001000;
    note_valid = 1'b1;
    step(48);                    // ticks 1..12 inject
    note_valid = 1'b0;
    note = '0;
    step(12);                    // E60+1
    for (int m = 15; m <= 26; m++) begin
      key = 7'b0001000;
      step(1);
      key = '0;
      if (m == 24) begin
        check("t3_score_at10", 32'(score), 32'd10);
        check("t3_combo_at10", 32'(combo), 32'd10);
      end
      step(3);
    end
    check("t3_score", 32'(score), 32'd14);
    check("t3_combo", 32'(combo), 32'd12);
    check("t3_no_miss", 32'(miss_cnt), 32'd0);
    inject(7'b0001000);
    step(68);
    check("t3_miss", 32'(miss_cnt), 32'd1);
    check("t3_combo_reset", 32'(combo), 32'd0);
    check("t3_score_kept", 32'(score), 32'd14);

    // Pause freezes scroll phase and judging; then a press on the tick edge at the judge row.
    do_reset();
    do_start();
    inject(7'b0000100);
    step(58);                    // E62+1: row 14, counter at 2
    pause = 1'b1;
    step(10);
    key = 7'b0000100;
    step(10);
    key = '0;
    step(10);
    key = 7'b0000100;
    step(10);
    check("t4_pause_score", 32'(score), 32'd0);
    check("t4_pause_combo", 32'(combo), 32'd0);
    check("t4_pause_bottom", 32'(lane_bottom), 32'h00);
    key = '0;
    pause = 1'b0;
    step(1);
    check("t4_phase_pre", 32'(lane_bottom), 32'h00);
    step(1);
    check("t4_phase_tick", 32'(lane_bottom), 32'h04);
    step(3);
    key = 7'b0000100;
    step(1);                     // tick edge and press together
    check("t4_edge_hit_score", 32'(score), 32'd1);
    check("t4_edge_hit_combo", 32'(combo), 32'd1);
    check("t4_edge_hit_miss", 32'(miss_cnt), 32'd0);
    key = '0;
    step(8);
    check("t4_no_late_miss", 32'(miss_cnt), 32'd0);

    // song_end flush to DONE, start ignored in RUN, restart clears.
    do_reset();
    do_start();
    inject(7'b0100000);          // E4+1
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t5_start_ignored", 32'(state), 32'd1);
    song_end = 1'b1;
    step(1);
    song_end = 1'b0;
    check("t5_flush", 32'(state), 32'd2);
    note = 7'b1000000;
    note_valid = 1'b1;
    step(61);                    // E67+1
    check("t5_still_flush", 32'(state), 32'd2);
    check("t5_in_flight", 32'(lane_bottom), 32'h20);
    step(3);                     // E70+1
    check("t5_done_state", 32'(state), 32'd3);
    check("t5_done", 32'(done), 32'd1);
    check("t5_flush_miss", 32'(miss_cnt), 32'd1);
    note_valid = 1'b0;
    note = '0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("t5_restart_state", 32'(state), 32'd1);
    check("t5_restart_clear", 32'(miss_cnt) | 32'(score) | 32'(combo), 32'd0);

    // Pixel path, lanes frozen by pause while vectors are applied.
    do_reset();
    do_start();
    inject(7'b0000010);
    step(20);                    // E24+1: row 5
    pause = 1'b1;
    for (int i = 0; i < 15; i++) apply_pix(tab_a[i], "pixA", i);
    key = '0;
    pause = 1'b0;
    step(32);                    // 8 more ticks: row 13
    pause = 1'b1;
    for (int i = 0; i < 5; i++) apply_pix(tab_b[i], "pixB", i);
    key = '0;
    pause = 1'b0;
    check("pix_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
